// File: rtl/sd_cmd_seq.sv
// SD card SPI-mode command sequencer.
// Shifts a 48-bit command frame out on DI, arms an external R1 response
// receiver, waits a bounded number of cycles for it, and reports the R1 byte
// or a timeout.
module sd_cmd_seq #(
  parameter int NCR_MAX = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdStart,
  input  logic [5:0]  cmdIndex,
  input  logic [31:0] cmdArg,
  input  logic [6:0]  cmdCrc,
  input  logic        DO,
  output logic        DI,
  output logic        CS,
  output logic        rpStart,
  output logic        rpDO,
  input  logic        rpFinish,
  input  logic [7:0]  rpResponse,
  output logic        isBusy,
  output logic        isFinish,
  output logic [7:0]  response,
  output logic        timeout
);

  // Wait counter must hold NCR_MAX itself, so size for NCR_MAX+1 values.
  localparam int CNT_W = (NCR_MAX < 1) ? 1 : $clog2(NCR_MAX + 1);
  localparam logic [CNT_W-1:0] W_LIMIT = CNT_W'(NCR_MAX);
  localparam logic [CNT_W-1:0] W_ONE   = CNT_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       r_state;
  logic [47:0]      r_frame;
  logic [5:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [7:0]       r_response;
  logic             r_timeout;

  logic w_accept;
  logic w_wait_hit;

  // A start is only honoured from IDLE; the wait limit is checked on the registered count.
  always_comb begin
    w_accept   = (r_state == S_IDLE) && cmdStart;
    w_wait_hit = (r_wait_cnt == W_LIMIT);
  end

  // Sequencer state, frame shift position and response wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_frame    <= '1;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_frame   <= {2'b01, cmdIndex, cmdArg, cmdCrc, 1'b1};
            r_bit_cnt <= 6'd47;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (r_bit_cnt == 6'd0) begin
            r_state <= S_ARM;
          end else begin
            r_bit_cnt <= r_bit_cnt - 6'd1;
          end
        end
        S_ARM: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // A response arriving on the limit cycle still counts as success.
          if (rpFinish) begin
            r_state <= S_DONE;
          end else if (w_wait_hit) begin
            r_state <= S_FLUSH;
          end else begin
            r_wait_cnt <= r_wait_cnt + W_ONE;
          end
        end
        S_FLUSH: begin
          if (rpFinish) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result registers: cleared on each accepted start, updated when the wait resolves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_response <= 8'h00;
      r_timeout  <= 1'b0;
    end else if (w_accept) begin
      r_response <= 8'h00;
      r_timeout  <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (rpFinish) begin
        r_response <= rpResponse;
        r_timeout  <= 1'b0;
      end else if (w_wait_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Card-side and handshake outputs decoded from the current state.
  always_comb begin
    DI       = 1'b1;
    CS       = 1'b1;
    rpStart  = 1'b0;
    rpDO     = DO;
    isBusy   = 1'b0;
    isFinish = 1'b0;
    case (r_state)
      S_SEND: begin
        DI     = r_frame[r_bit_cnt];
        CS     = 1'b0;
        isBusy = 1'b1;
      end
      S_ARM: begin
        CS      = 1'b0;
        rpStart = 1'b1;
        isBusy  = 1'b1;
      end
      S_WAIT: begin
        CS     = 1'b0;
        isBusy = 1'b1;
      end
      S_FLUSH: begin
        // Feed zeros so the receiver sees a start bit and completes on its own.
        CS     = 1'b0;
        rpDO   = 1'b0;
        isBusy = 1'b1;
      end
      S_DONE: begin
        CS       = 1'b0;
        isFinish = 1'b1;
      end
      default: begin
        DI = 1'b1;
      end
    endcase
  end

  assign response = r_response;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Self-checking bench for sd_cmd_seq: table vectors, random transactions
// against a cycle-numbered reference model, and reset-abort sequences.
module tb_sd_cmd_seq;

  localparam int NCR = 80;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmdStart;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArg;
  logic [6:0]  cmdCrc;
  logic        DO;
  logic        DI;
  logic        CS;
  logic        rpStart;
  logic        rpDO;
  logic        rpFinish;
  logic [7:0]  rpResponse;
  logic        isBusy;
  logic        isFinish;
  logic [7:0]  response;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  sd_cmd_seq #(.NCR_MAX(NCR)) dut (
    .clk(clk), .reset(reset), .cmdStart(cmdStart), .cmdIndex(cmdIndex),
    .cmdArg(cmdArg), .cmdCrc(cmdCrc), .DO(DO), .DI(DI), .CS(CS),
    .rpStart(rpStart), .rpDO(rpDO), .rpFinish(rpFinish),
    .rpResponse(rpResponse), .isBusy(isBusy), .isFinish(isFinish),
    .response(response), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    int          d;          // cycles from the rpStart cycle to the rpFinish cycle
    logic [7:0]  rsp;
    bit          do_high;
    int          inj_k;      // cycle to pulse a stray cmdStart, -1 for none
    logic [47:0] exp_frame;
    bit          exp_timeout;
    logic [7:0]  exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full command. Cycle k counts observations after the accept edge:
  // k=0..47 frame bits, k=48 rpStart, WAIT from k=49 with count k-49,
  // rpFinish driven at k=48+d, DONE observed at k=49+d.
  task automatic run_txn(input vec_t v);
    bit          ok;
    int          kf;
    bit          in_flush;
    logic [47:0] seen;
    bit          got_to;
    logic [7:0]  got_rsp;
    ok = (v.d <= NCR + 1);
    kf = 49 + v.d;
    seen = '0;
    got_to = 1'b0;
    got_rsp = 8'h00;
    cmdIndex = v.idx;
    cmdArg   = v.arg;
    cmdCrc   = v.crc;
    cmdStart = 1'b1;
    rpFinish = 1'b0;
    tick();
    cmdStart = 1'b0;
    for (int k = 0; k <= kf; k++) begin
      DO         = v.do_high ? 1'b1 : 1'($urandom_range(0, 1));
      rpFinish   = (k == 48 + v.d);
      rpResponse = (k == 48 + v.d) ? v.rsp : 8'($urandom);
      if (k == v.inj_k) begin
        cmdStart = 1'b1;
        cmdArg   = ~v.arg;
        cmdIndex = 6'($urandom);
        cmdCrc   = 7'($urandom);
      end else begin
        cmdStart = 1'b0;
      end
      #1;
      in_flush = !ok && (k >= NCR + 50) && (k <= 48 + v.d);
      check("DI", DI, (k <= 47) ? v.exp_frame[47-k] : 1'b1);
      check("CS", CS, 1'b0);
      check("rpStart", rpStart, k == 48);
      check("isBusy", isBusy, k < kf);
      check("isFinish", isFinish, k == kf);
      check("rpDO", rpDO, in_flush ? 1'b0 : DO);
      check("timeout", timeout, !ok && (k >= NCR + 50));
      check("response", response, (ok && k >= kf) ? v.rsp : 8'h00);
      if (k <= 47) seen[47-k] = DI;
      if (k == kf) begin
        got_to  = timeout;
        got_rsp = response;
      end
      tick();
    end
    cmdStart = 1'b0;
    rpFinish = 1'b0;
    #1;
    check("frame", seen, v.exp_frame);
    check("final_timeout", got_to, v.exp_timeout);
    check("final_response", got_rsp, v.exp_resp);
    // Back in IDLE with results held.
    check("idle_CS", CS, 1'b1);
    check("idle_busy", isBusy, 1'b0);
    check("idle_finish", isFinish, 1'b0);
    check("idle_DI", DI, 1'b1);
    check("hold_timeout", timeout, v.exp_timeout);
    check("hold_response", response, v.exp_resp);
    tick();
    check("no_second_txn", CS, 1'b1);
    $display("[TB] txn idx=%02h arg=%08h d=%0d inj=%0d -> timeout=%0b response=%02h",
             v.idx, v.arg, v.d, v.inj_k, got_to, got_rsp);
  endtask

  // Start a command then assert reset after at_k observation cycles.
  task automatic reset_abort(input int at_k);
    cmdIndex = 6'($urandom);
    cmdArg   = $urandom;
    cmdCrc   = 7'($urandom);
    cmdStart = 1'b1;
    rpFinish = 1'b0;
    tick();
    cmdStart = 1'b0;
    for (int k = 0; k < at_k; k++) begin
      DO = 1'($urandom_range(0, 1));
      tick();
    end
    #1;
    check("pre_reset_busy", isBusy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    DO = 1'($urandom_range(0, 1));
    #1;
    check("rst_DI", DI, 1'b1);
    check("rst_CS", CS, 1'b1);
    check("rst_busy", isBusy, 1'b0);
    check("rst_finish", isFinish, 1'b0);
    check("rst_rpStart", rpStart, 1'b0);
    check("rst_rpDO", rpDO, DO);
    check("rst_timeout", timeout, 1'b0);
    check("rst_response", response, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_finish", isFinish, 1'b0);
      check("post_rst_CS", CS, 1'b1);
    end
    $display("[TB] reset abort at cycle %0d", at_k);
  endtask

  initial begin
    vec_t v;
    reset      = 1'b1;
    cmdStart   = 1'b0;
    cmdIndex   = '0;
    cmdArg     = '0;
    cmdCrc     = '0;
    DO         = 1'b1;
    rpFinish   = 1'b0;
    rpResponse = 8'h00;

    // Hand-derived frames and results.
    vecs[0] = '{6'h00, 32'h0000_0000, 7'h4A, 10,      8'h01, 1'b0, -1, 48'h40_0000_0000_95, 1'b0, 8'h01};
    vecs[1] = '{6'h11, 32'h0000_0200, 7'h2A, 3,       8'hFE, 1'b0, -1, 48'h51_0000_0200_55, 1'b0, 8'hFE};
    vecs[2] = '{6'h3A, 32'hDEAD_BEEF, 7'h7F, NCR + 5, 8'hA5, 1'b1, -1, 48'h7A_DEAD_BEEF_FF, 1'b1, 8'h00};
    vecs[3] = '{6'h08, 32'h0000_01AA, 7'h43, NCR + 1, 8'h05, 1'b0, -1, 48'h48_0000_01AA_87, 1'b0, 8'h05};
    vecs[4] = '{6'h37, 32'h0000_0000, 7'h32, NCR + 2, 8'h3C, 1'b1, -1, 48'h77_0000_0000_65, 1'b1, 8'h00};
    vecs[5] = '{6'h01, 32'h0000_0000, 7'h7C, 1,       8'h00, 1'b0, 20, 48'h41_0000_0000_F9, 1'b0, 8'h00};

    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_DI", DI, 1'b1);
    check("reset_CS", CS, 1'b1);
    check("reset_rpStart", rpStart, 1'b0);
    check("reset_busy", isBusy, 1'b0);
    check("reset_finish", isFinish, 1'b0);
    check("reset_response", response, 8'h00);
    check("reset_timeout", timeout, 1'b0);
    check("reset_rpDO", rpDO, DO);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    reset_abort(20);
    run_txn(vecs[0]);
    reset_abort(70);
    run_txn(vecs[3]);

    // Randomized transactions; expectations come from the cycle-numbered model.
    for (int i = 0; i < 12; i++) begin
      v.idx         = 6'($urandom);
      v.arg         = $urandom;
      v.crc         = 7'($urandom);
      v.d           = $urandom_range(1, NCR + 10);
      v.rsp         = 8'($urandom);
      v.do_high     = 1'($urandom_range(0, 1));
      v.inj_k       = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 49 + v.d);
      v.exp_frame   = {2'b01, v.idx, v.arg, v.crc, 1'b1};
      v.exp_timeout = (v.d > NCR + 1);
      v.exp_resp    = v.exp_timeout ? 8'h00 : v.rsp;
      run_txn(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
